mips_pc_alu_unit: RTL and testbench
===================================

// Module: mips_pc_alu_unit
// PURPOSE
// Single-cycle MIPS execute/fetch-address core: the program-counter register
// (synchronous-reset flop), PC+4 and branch-target adders, next-PC selection
// (sequential/branch/jump), and the 32-bit ALU. Register file, muxes for ALU
// operands and memories sit outside in the surrounding datapath.
// PARAMETERS
// WIDTH      32           datapath width (only 32 is supported)
// RESET_PC   32'h0000_0000  PC value loaded on reset
// PORTS
// clk_i          in   1   clock, all state updates on rising edge
// reset_i        in   1   reset: synchronous and active-high
// pc_branch_i    in   1   1 = take branch target next cycle
// pc_j_i         in   1   1 = take jump target next cycle (overrides branch)
// sign_imm_i32   in   32  sign-extended 16-bit immediate (branch offset, words)
// jaddr_i26      in   26  instr[25:0] jump index
// a_i32          in   32  ALU operand A
// b_i32          in   32  ALU operand B
// funct_i6       in   6   instr[5:0] R-type function code
// alt_ctrl_i2    in   2   ALU op class from main decoder
// pc_o32         out  32  current PC (registered)
// pc_plus4_o32   out  32  pc_o32 + 4 (combinational)
// alu_out_o32    out  32  ALU result (combinational)
// zero_o         out  1   1 when alu_out_o32 == 0
// BEHAVIOUR
// - Reset: clk edge with reset_i=1 -> pc_o32 = RESET_PC; reset overrides all
//   next-PC selects; asserting mid-program takes effect at that edge only.
// - Non-reset edge: pc_o32 <= pc_next (1-cycle latency); no stall/enable.
// - pc_plus4 = pc + 4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
// - pc_branch = pc_plus4 + (sign_imm_i32 << 2), modulo 2^32; negative offsets
//   branch backwards.
// - pc_jump = {pc_plus4[31:28], jaddr_i26, 2'b00}.
// - pc_next: pc_j_i=1 -> pc_jump; else pc_branch_i=1 -> pc_branch; else pc_plus4.
//   Both selects high: jump wins.
// - ALU purely combinational, no carry/overflow outputs, no traps.
//   alt_ctrl_i2: 00 add (lw/sw/addi); 01 sub A-B (beq); 10 decode funct;
//   11 OR (ori).
// - funct (alt=10): 100000/100001 add; 100010/100011 sub; 100100 and;
//   100101 or; 100110 xor; 100111 nor; 101010 slt signed (1/0);
//   101011 sltu unsigned; 000000 sll A<<B[4:0]; 000010 srl A>>B[4:0] logical;
//   000011 sra arithmetic. Shifts use only B[4:0]; datapath feeds rt on A,
//   shamt on B. Undefined funct -> result 0 (zero_o=1).
// - Add/sub wrap modulo 2^32; zero_o derived from final result in all modes.
// TESTING
// - Reset: reset_i=1 one edge -> pc_o32=0; release, 3 edges, no selects ->
//   pc 4, 8, 12.
// - Branch: pc=0x10, sign_imm=0xFFFF_FFFE, pc_branch_i=1 -> next pc=0x0C;
//   with pc_j_i=1, jaddr=0x0000040 also high -> next pc=0x100.
// - Wrap: force pc to 0xFFFF_FFFC via jump chain/offset -> next sequential 0.
// - ALU: alt=00 7+5=12; alt=01 5-5=0 zero_o=1; alt=10 slt -1,1 -> 1,
//   sltu -1,1 -> 0; alt=11 0xF0|0x0F=0xFF.
// - Shifts: A=0x8000_0001, B=4 -> sll 0x0000_0010, srl 0x0800_0000,
//   sra 0xF800_0000; B=0x24 behaves as B=4.
// - Reset mid-run: reset_i=1 while pc_branch_i=1 -> pc_o32=0, not branch target.

Source files
------------

// File: rtl/mips_pc_alu_unit.sv
// rtl/mips_pc_alu_unit.sv - MIPS program counter, next-PC selection and 32-bit ALU
// The PC flop updates every edge; all other outputs are combinational.

module mips_pc_alu_unit #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             pc_branch_i,
    input  logic             pc_j_i,
    input  logic [WIDTH-1:0] sign_imm_i32,
    input  logic [25:0]      jaddr_i26,
    input  logic [WIDTH-1:0] a_i32,
    input  logic [WIDTH-1:0] b_i32,
    input  logic [5:0]       funct_i6,
    input  logic [1:0]       alt_ctrl_i2,
    output logic [WIDTH-1:0] pc_o32,
    output logic [WIDTH-1:0] pc_plus4_o32,
    output logic [WIDTH-1:0] alu_out_o32,
    output logic             zero_o
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_branch;
    logic [WIDTH-1:0] pc_jump;
    logic [WIDTH-1:0] alu_res;
    logic [4:0]       shamt;

    assign pc_plus4  = pc_q + 32'd4;
    assign pc_branch = pc_plus4 + (sign_imm_i32 << 2);
    assign pc_jump   = {pc_plus4[WIDTH-1:WIDTH-4], jaddr_i26, 2'b00};

    // Jump has priority over branch when both selects are asserted.
    always_comb begin
        pc_d = pc_plus4;
        if (pc_j_i) begin
            pc_d = pc_jump;
        end else if (pc_branch_i) begin
            pc_d = pc_branch;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign shamt = b_i32[4:0];

    always_comb begin
        alu_res = '0;
        case (alt_ctrl_i2)
            2'b00: alu_res = a_i32 + b_i32;
            2'b01: alu_res = a_i32 - b_i32;
            2'b11: alu_res = a_i32 | b_i32;
            default: begin
                case (funct_i6)
                    6'b100000, 6'b100001: alu_res = a_i32 + b_i32;
                    6'b100010, 6'b100011: alu_res = a_i32 - b_i32;
                    6'b100100: alu_res = a_i32 & b_i32;
                    6'b100101: alu_res = a_i32 | b_i32;
                    6'b100110: alu_res = a_i32 ^ b_i32;
                    6'b100111: alu_res = ~(a_i32 | b_i32);
                    6'b101010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_i32) < $signed(b_i32))};
                    6'b101011: alu_res = {{(WIDTH-1){1'b0}}, (a_i32 < b_i32)};
                    6'b000000: alu_res = a_i32 << shamt;
                    6'b000010: alu_res = a_i32 >> shamt;
                    6'b000011: alu_res = $signed(a_i32) >>> shamt;
                    default:   alu_res = '0;
                endcase
            end
        endcase
    end

    assign pc_o32       = pc_q;
    assign pc_plus4_o32 = pc_plus4;
    assign alu_out_o32  = alu_res;
    assign zero_o       = (alu_res == '0);

endmodule

// File: tb/tb_mips_pc_alu_unit.sv
// tb/tb_mips_pc_alu_unit.sv - scoreboard bench for mips_pc_alu_unit
// Stimulus queues expected values tagged with a due cycle; the monitor checks them at negedge.

module tb_mips_pc_alu_unit;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        pc_branch_i = 1'b0;
    logic        pc_j_i = 1'b0;
    logic [31:0] sign_imm_i32 = '0;
    logic [25:0] jaddr_i26 = '0;
    logic [31:0] a_i32 = '0;
    logic [31:0] b_i32 = '0;
    logic [5:0]  funct_i6 = '0;
    logic [1:0]  alt_ctrl_i2 = '0;
    logic [31:0] pc_o32;
    logic [31:0] pc_plus4_o32;
    logic [31:0] alu_out_o32;
    logic        zero_o;

    mips_pc_alu_unit dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .pc_branch_i  (pc_branch_i),
        .pc_j_i       (pc_j_i),
        .sign_imm_i32 (sign_imm_i32),
        .jaddr_i26    (jaddr_i26),
        .a_i32        (a_i32),
        .b_i32        (b_i32),
        .funct_i6     (funct_i6),
        .alt_ctrl_i2  (alt_ctrl_i2),
        .pc_o32       (pc_o32),
        .pc_plus4_o32 (pc_plus4_o32),
        .alu_out_o32  (alu_out_o32),
        .zero_o       (zero_o)
    );

    always #5 clk = ~clk;

    localparam int SEL_PC = 0, SEL_PC4 = 1, SEL_ALU = 2, SEL_ZERO = 3;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    string       q_name[$];
    int          q_sel[$];
    logic [31:0] q_exp[$];
    int          q_due[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string name, input int sel, input logic [31:0] exp);
        q_name.push_back(name);
        q_sel.push_back(sel);
        q_exp.push_back(exp);
        q_due.push_back(cyc);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q_due.size() > 0 && q_due[0] <= cyc) begin
            logic [31:0] got;
            string       nm;
            logic [31:0] ex;
            int          sl;
            int          due;
            nm  = q_name.pop_front();
            sl  = q_sel.pop_front();
            ex  = q_exp.pop_front();
            due = q_due.pop_front();
            case (sl)
                SEL_PC:   got = pc_o32;
                SEL_PC4:  got = pc_plus4_o32;
                SEL_ALU:  got = alu_out_o32;
                default:  got = {31'b0, zero_o};
            endcase
            checks++;
            if (due < cyc) begin
                errors++;
                $display("FAIL %s: missed check window (due %0d, now %0d)", nm, due, cyc);
            end else if (got !== ex) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, ex);
            end
        end
    end

    typedef struct {
        logic [1:0]  alt;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } alu_vec_t;

    alu_vec_t vecs[$];

    initial begin
        vecs.push_back('{2'b00, 6'b000000, 32'd7,          32'd5,          32'd12});
        vecs.push_back('{2'b01, 6'b000000, 32'd5,          32'd5,          32'd0});
        vecs.push_back('{2'b10, 6'b101010, 32'hFFFF_FFFF,  32'd1,          32'd1});
        vecs.push_back('{2'b10, 6'b101011, 32'hFFFF_FFFF,  32'd1,          32'd0});
        vecs.push_back('{2'b10, 6'b101010, 32'd1,          32'hFFFF_FFFF,  32'd0});
        vecs.push_back('{2'b10, 6'b101011, 32'd1,          32'hFFFF_FFFF,  32'd1});
        vecs.push_back('{2'b11, 6'b000000, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF});
        vecs.push_back('{2'b10, 6'b000000, 32'h8000_0001,  32'd4,          32'h0000_0010});
        vecs.push_back('{2'b10, 6'b000010, 32'h8000_0001,  32'd4,          32'h0800_0000});
        vecs.push_back('{2'b10, 6'b000011, 32'h8000_0001,  32'd4,          32'hF800_0000});
        vecs.push_back('{2'b10, 6'b000000, 32'h8000_0001,  32'h24,         32'h0000_0010});
        vecs.push_back('{2'b10, 6'b000010, 32'h8000_0001,  32'h24,         32'h0800_0000});
        vecs.push_back('{2'b10, 6'b000011, 32'h8000_0001,  32'h24,         32'hF800_0000});
        vecs.push_back('{2'b10, 6'b100000, 32'hFFFF_FFFF,  32'd1,          32'd0});
        vecs.push_back('{2'b10, 6'b100001, 32'd3,          32'd4,          32'd7});
        vecs.push_back('{2'b10, 6'b100010, 32'd3,          32'd4,          32'hFFFF_FFFF});
        vecs.push_back('{2'b10, 6'b100011, 32'd10,         32'd3,          32'd7});
        vecs.push_back('{2'b10, 6'b100100, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000});
        vecs.push_back('{2'b10, 6'b100101, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF});
        vecs.push_back('{2'b10, 6'b100110, 32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0});
        vecs.push_back('{2'b10, 6'b100111, 32'd0,          32'd0,          32'hFFFF_FFFF});
        vecs.push_back('{2'b10, 6'b111111, 32'd5,          32'd5,          32'd0});
    end

    initial begin
        // Reset, then three sequential steps
        reset_i = 1'b1;
        cycle();
        push("reset_pc", SEL_PC, 32'h0);
        push("reset_pc4", SEL_PC4, 32'h4);
        reset_i = 1'b0;
        cycle(); push("seq_pc4", SEL_PC, 32'h4);
        cycle(); push("seq_pc8", SEL_PC, 32'h8);
        cycle(); push("seq_pc12", SEL_PC, 32'hC);
        cycle(); push("seq_pc16", SEL_PC, 32'h10);

        // Backward branch from 0x10
        pc_branch_i = 1'b1; sign_imm_i32 = 32'hFFFF_FFFE;
        cycle(); push("branch_back", SEL_PC, 32'h0000_000C);

        // Jump overrides branch
        pc_j_i = 1'b1; jaddr_i26 = 26'h0000040;
        cycle(); push("jump_over_branch", SEL_PC, 32'h0000_0100);

        // Branch to 0xFFFF_FFFC then wrap sequentially
        pc_j_i = 1'b0; sign_imm_i32 = 32'hFFFF_FFBE;
        cycle(); push("branch_to_top", SEL_PC, 32'hFFFF_FFFC);
        push("pc4_wrap", SEL_PC4, 32'h0);
        pc_branch_i = 1'b0;
        cycle(); push("seq_wrap", SEL_PC, 32'h0);

        // Jump keeps the upper nibble of pc+4
        pc_branch_i = 1'b1; sign_imm_i32 = 32'h1FFF_FFFB;
        cycle(); push("branch_fwd", SEL_PC, 32'h7FFF_FFF0);
        pc_branch_i = 1'b0; pc_j_i = 1'b1; jaddr_i26 = 26'h3FF_FFFF;
        cycle(); push("jump_upper_nibble", SEL_PC, 32'h7FFF_FFFC);

        // Reset wins over branch mid-run
        pc_j_i = 1'b0; pc_branch_i = 1'b1; sign_imm_i32 = 32'd5; reset_i = 1'b1;
        cycle(); push("mid_reset", SEL_PC, 32'h0);
        reset_i = 1'b0; pc_branch_i = 1'b0;
        cycle(); push("post_reset_seq", SEL_PC, 32'h4);

        foreach (vecs[i]) begin
            alt_ctrl_i2 = vecs[i].alt;
            funct_i6    = vecs[i].funct;
            a_i32       = vecs[i].a;
            b_i32       = vecs[i].b;
            push($sformatf("alu_res[%0d]", i), SEL_ALU, vecs[i].res);
            push($sformatf("alu_zero[%0d]", i), SEL_ZERO, {31'b0, (vecs[i].res == 32'd0)});
            cycle();
        end

        cycle();
        cycle();
        while (q_name.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL %s: never checked, expected 0x%08h", q_name.pop_front(), q_exp.pop_front());
            void'(q_sel.pop_front());
            void'(q_due.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
